// File: rtl/cmpr_err_accum_if.sv
// cmpr_err_accum_if: window control, compare samples and window results for cmpr_err_accum
interface cmpr_err_accum_if #(
    parameter int width     = 4,
    parameter int cnt_width = 16,
    parameter int len_width = 16
);
    logic                 start;
    logic [len_width-1:0] num_samples;
    logic [width-1:0]     cmp_in;
    logic                 cmp_enable;
    logic                 busy;
    logic                 done;
    logic                 err_flag;
    logic [cnt_width-1:0] err_count;
    logic [len_width-1:0] sample_count;
    logic [len_width-1:0] first_err_idx;
    logic                 first_err_valid;
    modport master (
        output start, num_samples, cmp_in, cmp_enable,
        input  busy, done, err_flag, err_count, sample_count, first_err_idx, first_err_valid
    );
    modport slave (
        input  start, num_samples, cmp_in, cmp_enable,
        output busy, done, err_flag, err_count, sample_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/cmpr_err_accum.sv
// cmpr_err_accum: counts samples and mismatches over a test window; CMPR_ERR_FIRST_CAPTURE_EN adds first-mismatch index capture
module cmpr_err_accum #(
    parameter int width     = 4,
    parameter int cnt_width = 16,
    parameter int len_width = 16
) (
    input logic              clk,
    input logic              rst_n,
    cmpr_err_accum_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [len_width-1:0] len_one = 1;
    localparam logic [cnt_width-1:0] cnt_one = 1;
    state_t               state, state_nxt;
    logic [len_width-1:0] target, sample_count;
    logic [cnt_width-1:0] err_count;
    logic                 err_flag;
    logic                 mismatch, accept, last, clear;
    assign mismatch = |bus.cmp_in;
    assign accept   = state == RUN && bus.cmp_enable;
    assign last     = sample_count + len_one == target;
    assign clear    = state == IDLE && bus.start;
    // state register
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    // next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        if (state == IDLE && bus.start) state_nxt = bus.num_samples != '0 ? RUN : DONE;
        if (state == RUN) begin
            bus.busy  = 1'b1;
            state_nxt = accept && last ? DONE : RUN;
        end
        if (state == DONE) begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
        end
    end
    // window target, sample and saturating mismatch counters
    always_ff @(posedge clk)
        if (!rst_n) begin
            target       <= '0;
            sample_count <= '0;
            err_count    <= '0;
            err_flag     <= 1'b0;
        end else if (clear) begin
            target       <= bus.num_samples;
            sample_count <= '0;
            err_count    <= '0;
            err_flag     <= 1'b0;
        end else if (accept) begin
            sample_count <= sample_count + len_one;
            if (mismatch) begin
                err_flag  <= 1'b1;
                err_count <= &err_count ? err_count : err_count + cnt_one;
            end
        end
    assign bus.err_flag     = err_flag;
    assign bus.err_count    = err_count;
    assign bus.sample_count = sample_count;
`ifdef CMPR_ERR_FIRST_CAPTURE_EN
    logic [len_width-1:0] first_idx;
    logic                 first_valid;
    // capture the pre-increment index of the first mismatch in the window
    always_ff @(posedge clk)
        if (!rst_n || clear) begin
            first_idx   <= '0;
            first_valid <= 1'b0;
        end else if (accept && mismatch && !first_valid) begin
            first_idx   <= sample_count;
            first_valid <= 1'b1;
        end
    assign bus.first_err_idx   = first_idx;
    assign bus.first_err_valid = first_valid;
`else
    assign bus.first_err_idx   = '0;
    assign bus.first_err_valid = 1'b0;
`endif
endmodule

// File: tb/tb_cmpr_err_accum.sv
// tb_cmpr_err_accum: randomized windows scored against a per-window model of cmpr_err_accum
module tb_cmpr_err_accum;
    localparam int W  = 4;
    localparam int CW = 4;
    localparam int LW = 16;
    localparam int SAT = (1 << CW) - 1;
    typedef struct {
        int n;
        int errs;
        bit flag;
        int fidx;
        bit fvalid;
        int run;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cmpr_err_accum_if #(.width(W), .cnt_width(CW), .len_width(LW)) bus ();
    cmpr_err_accum #(.width(W), .cnt_width(CW), .len_width(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    exp_t q[$];
    exp_t cur, last_e;
    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int done_seen = 0;
    int windows = 0;
    bit done_prev = 1'b0;
    task automatic check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_zero(string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err_flag"}, bus.err_flag, 0);
        check({tag, "_err_count"}, bus.err_count, 0);
        check({tag, "_sample_count"}, bus.sample_count, 0);
        check({tag, "_first_idx"}, bus.first_err_idx, 0);
        check({tag, "_first_valid"}, bus.first_err_valid, 0);
    endtask
    // monitor: score every done pulse against the oldest outstanding window
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                check("done_one_cycle", bus.done, 0);
                check("hold_sample_count", bus.sample_count, last_e.n);
                check("hold_err_count", bus.err_count, last_e.errs);
            end
            if (bus.busy) busy_cnt++;
            done_prev = bus.done;
            if (bus.done) begin
                if (q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    cur = q.pop_front();
                    check("sample_count", bus.sample_count, cur.n);
                    check("err_count", bus.err_count, cur.errs);
                    check("err_flag", bus.err_flag, cur.flag);
                    check("first_err_idx", bus.first_err_idx, cur.fidx);
                    check("first_err_valid", bus.first_err_valid, cur.fvalid);
                    check("busy_cycles", busy_cnt, cur.run);
                    check("busy_at_done", bus.busy, 0);
                    last_e = cur;
                    done_seen++;
                end
                busy_cnt = 0;
            end
        end
    end
    // mode: 0 clean, 1 all mismatch, 2 random mismatch, 3 mismatches at 3 and 7
    task automatic run_window(int n, int mode, int bub_pct, int restart_at, int abort_at);
        logic [W-1:0] vals[$];
        int bubs[$];
        exp_t e;
        int errs;
        bit mm;
        errs = 0;
        e.n = n; e.fidx = 0; e.fvalid = 0; e.run = n;
        for (int i = 0; i < n; i++) begin
            mm = mode == 1 || (mode == 2 && $urandom_range(99) < 30) || (mode == 3 && (i == 3 || i == 7));
            vals.push_back(!mm ? '0 : mode == 3 ? W'(1) : W'($urandom_range(15, 1)));
            bubs.push_back($urandom_range(99) < bub_pct ? $urandom_range(3, 1) : 0);
            e.run += bubs[i];
            if (mm) begin
                if (errs == 0) begin
                    e.fidx = i;
                    e.fvalid = 1;
                end
                errs++;
            end
        end
        e.errs = errs > SAT ? SAT : errs;
        e.flag = errs > 0;
`ifndef CMPR_ERR_FIRST_CAPTURE_EN
        e.fidx = 0;
        e.fvalid = 0;
`endif
        q.push_back(e);
        windows++;
        bus.start = 1'b1;
        bus.num_samples = LW'(n);
        bus.cmp_enable = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                chk_zero("abort");
                rst_n = 1'b1;
                void'(q.pop_back());
                windows--;
                bus.cmp_enable = 1'b0;
                bus.start = 1'b0;
                return;
            end
            repeat (bubs[i]) begin
                bus.cmp_enable = 1'b0;
                bus.cmp_in = W'($urandom_range(15));
                bus.start = $urandom_range(99) < 10;
                bus.num_samples = LW'($urandom_range(5, 1));
                @(posedge clk); #1;
            end
            bus.cmp_enable = 1'b1;
            bus.cmp_in = vals[i];
            bus.start = i == restart_at;
            bus.num_samples = LW'($urandom_range(5, 1));
            @(posedge clk); #1;
        end
        bus.start = $urandom_range(1);
        bus.cmp_enable = $urandom_range(1);
        bus.cmp_in = W'($urandom_range(15));
        bus.num_samples = LW'($urandom_range(5, 1));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat ($urandom_range(2)) begin
            bus.cmp_enable = $urandom_range(1);
            bus.cmp_in = W'($urandom_range(15));
            @(posedge clk); #1;
        end
        bus.cmp_enable = 1'b0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.num_samples = '0;
        bus.cmp_in = '0;
        bus.cmp_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(8, 0, 0, -1, -1);
        run_window(10, 3, 50, -1, -1);
        run_window(20, 1, 20, -1, -1);
        run_window(0, 0, 0, -1, -1);
        run_window(6, 2, 30, 2, -1);
        run_window(8, 2, 30, -1, 3);
        repeat (3) @(posedge clk);
        #1;
        run_window(4, 2, 30, -1, -1);
        for (int k = 0; k < 40; k++)
            run_window($urandom_range(24), $urandom_range(2), 30,
                       $urandom_range(99) < 30 ? $urandom_range(3) : -1, -1);
        for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clk);
        #1;
        check("pending_windows", q.size(), 0);
        check("done_count", done_seen, windows);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
